// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - round-robin arbiter sharing one 16->32 immediate extender between two ports
module imm_ext_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqValidA,
    output logic             ReqReadyA,
    input  logic [15:0]      ReqImmA,
    input  logic [1:0]       ReqModeA,
    output logic             RspValidA,
    input  logic             RspReadyA,
    output logic [31:0]      RspDataA,
    output logic             RspErrA,
    input  logic             ReqValidB,
    output logic             ReqReadyB,
    input  logic [15:0]      ReqImmB,
    input  logic [1:0]       ReqModeB,
    output logic             RspValidB,
    input  logic             RspReadyB,
    output logic [31:0]      RspDataB,
    output logic             RspErrB,
    output logic [CNT_W-1:0] ConflictCnt
);

    // prio_b_q: 0 = port A wins a tie, 1 = port B wins a tie
    logic             prio_b_q, prio_b_d;
    logic             rsp_valid_a_q, rsp_valid_a_d;
    logic [31:0]      rsp_data_a_q, rsp_data_a_d;
    logic             rsp_err_a_q, rsp_err_a_d;
    logic             rsp_valid_b_q, rsp_valid_b_d;
    logic [31:0]      rsp_data_b_q, rsp_data_b_d;
    logic             rsp_err_b_q, rsp_err_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        elig_a, elig_b;
    logic        grant_a, grant_b;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] ext_data;
    logic        ext_err;

    // Grants are held off while reset is asserted so nothing is accepted then lost.
    always_comb begin
        elig_a  = Rst && ReqValidA && (!rsp_valid_a_q || RspReadyA);
        elig_b  = Rst && ReqValidB && (!rsp_valid_b_q || RspReadyB);
        grant_a = elig_a && (!elig_b || !prio_b_q);
        grant_b = elig_b && (!elig_a || prio_b_q);
    end

    // Only the granted immediate reaches the extender, so X on an idle port stays out.
    always_comb begin
        imm  = 16'h0000;
        mode = 2'b00;
        if (grant_a) begin
            imm  = ReqImmA;
            mode = ReqModeA;
        end else if (grant_b) begin
            imm  = ReqImmB;
            mode = ReqModeB;
        end
        ext_err = (mode == 2'b11);
        case (mode)
            2'b01:   ext_data = {16'h0000, imm};
            2'b10:   ext_data = {imm, 16'h0000};
            default: ext_data = {{16{imm[15]}}, imm};
        endcase
    end

    always_comb begin
        prio_b_d      = prio_b_q;
        rsp_valid_a_d = rsp_valid_a_q;
        rsp_data_a_d  = rsp_data_a_q;
        rsp_err_a_d   = rsp_err_a_q;
        rsp_valid_b_d = rsp_valid_b_q;
        rsp_data_b_d  = rsp_data_b_q;
        rsp_err_b_d   = rsp_err_b_q;
        cnt_d         = cnt_q;

        if (grant_a) begin
            prio_b_d = 1'b1;
        end else if (grant_b) begin
            prio_b_d = 1'b0;
        end

        if (grant_a) begin
            rsp_valid_a_d = 1'b1;
            rsp_data_a_d  = ext_data;
            rsp_err_a_d   = ext_err;
        end else if (RspReadyA) begin
            rsp_valid_a_d = 1'b0;
        end

        if (grant_b) begin
            rsp_valid_b_d = 1'b1;
            rsp_data_b_d  = ext_data;
            rsp_err_b_d   = ext_err;
        end else if (RspReadyB) begin
            rsp_valid_b_d = 1'b0;
        end

        if (elig_a && elig_b && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            prio_b_q      <= 1'b0;
            rsp_valid_a_q <= 1'b0;
            rsp_data_a_q  <= 32'h0;
            rsp_err_a_q   <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            rsp_data_b_q  <= 32'h0;
            rsp_err_b_q   <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            prio_b_q      <= prio_b_d;
            rsp_valid_a_q <= rsp_valid_a_d;
            rsp_data_a_q  <= rsp_data_a_d;
            rsp_err_a_q   <= rsp_err_a_d;
            rsp_valid_b_q <= rsp_valid_b_d;
            rsp_data_b_q  <= rsp_data_b_d;
            rsp_err_b_q   <= rsp_err_b_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ReqReadyA   = grant_a;
    assign ReqReadyB   = grant_b;
    assign RspValidA   = rsp_valid_a_q;
    assign RspDataA    = rsp_data_a_q;
    assign RspErrA     = rsp_err_a_q;
    assign RspValidB   = rsp_valid_b_q;
    assign RspDataB    = rsp_data_b_q;
    assign RspErrB     = rsp_err_b_q;
    assign ConflictCnt = cnt_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - randomized self-checking bench for imm_ext_arbiter against a behavioural model
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic [15:0] req_imm_a, req_imm_b;
    logic [1:0]  req_mode_a, req_mode_b;
    logic        rsp_ready_a, rsp_ready_b;

    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic [15:0] conflict_cnt;

    logic        s_req_ready_a, s_req_ready_b, s_rsp_valid_a, s_rsp_valid_b, s_rsp_err_a, s_rsp_err_b;
    logic [31:0] s_rsp_data_a, s_rsp_data_b;
    logic [2:0]  s_conflict_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: one record per port plus "who was granted last" and conflict tallies.
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    bit          m_err   [2];
    int          m_last_winner;
    int          m_cnt16, m_cnt3;

    always #5 clk = ~clk;

    imm_ext_arbiter #(.CNT_W(16)) dut (
        .Clk(clk), .Rst(rst),
        .ReqValidA(req_valid_a), .ReqReadyA(req_ready_a), .ReqImmA(req_imm_a), .ReqModeA(req_mode_a),
        .RspValidA(rsp_valid_a), .RspReadyA(rsp_ready_a), .RspDataA(rsp_data_a), .RspErrA(rsp_err_a),
        .ReqValidB(req_valid_b), .ReqReadyB(req_ready_b), .ReqImmB(req_imm_b), .ReqModeB(req_mode_b),
        .RspValidB(rsp_valid_b), .RspReadyB(rsp_ready_b), .RspDataB(rsp_data_b), .RspErrB(rsp_err_b),
        .ConflictCnt(conflict_cnt)
    );

    imm_ext_arbiter #(.CNT_W(3)) dut_sat (
        .Clk(clk), .Rst(rst),
        .ReqValidA(req_valid_a), .ReqReadyA(s_req_ready_a), .ReqImmA(req_imm_a), .ReqModeA(req_mode_a),
        .RspValidA(s_rsp_valid_a), .RspReadyA(rsp_ready_a), .RspDataA(s_rsp_data_a), .RspErrA(s_rsp_err_a),
        .ReqValidB(req_valid_b), .ReqReadyB(s_req_ready_b), .ReqImmB(req_imm_b), .ReqModeB(req_mode_b),
        .RspValidB(s_rsp_valid_b), .RspReadyB(rsp_ready_b), .RspDataB(s_rsp_data_b), .RspErrB(s_rsp_err_b),
        .ConflictCnt(s_conflict_cnt)
    );

    function automatic logic [31:0] ext_value(input logic [15:0] imm, input logic [1:0] mode);
        int signed sv;
        if (mode == 2'd1) return 32'(imm);
        if (mode == 2'd2) return 32'(imm) * 32'h0001_0000;
        sv = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        return 32'(sv);
    endfunction

    // Which port the model expects to be granted now (-1 = none).
    function automatic int model_winner();
        bit want_a, want_b;
        want_a = rst && req_valid_a && (!m_valid[0] || rsp_ready_a);
        want_b = rst && req_valid_b && (!m_valid[1] || rsp_ready_b);
        if (want_a && want_b) return (m_last_winner == 0) ? 1 : 0;
        if (want_a) return 0;
        if (want_b) return 1;
        return -1;
    endfunction

    task automatic tick();
        int  w;
        bit  both;
        w    = model_winner();
        both = rst && req_valid_a && (!m_valid[0] || rsp_ready_a)
                   && req_valid_b && (!m_valid[1] || rsp_ready_b);
        @(posedge clk);
        if (!rst) begin
            m_valid = '{0, 0};
            m_data  = '{32'h0, 32'h0};
            m_err   = '{0, 0};
            m_last_winner = 1;
            m_cnt16 = 0;
            m_cnt3  = 0;
        end else begin
            if (rsp_ready_a) m_valid[0] = 0;
            if (rsp_ready_b) m_valid[1] = 0;
            if (w == 0) begin
                m_valid[0] = 1;
                m_data[0]  = ext_value(req_imm_a, req_mode_a);
                m_err[0]   = (req_mode_a == 2'd3);
            end else if (w == 1) begin
                m_valid[1] = 1;
                m_data[1]  = ext_value(req_imm_b, req_mode_b);
                m_err[1]   = (req_mode_b == 2'd3);
            end
            if (w >= 0) m_last_winner = w;
            if (both) begin
                m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                m_cnt3  = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        req_imm_a = 16'h1111; req_mode_a = 2'd0;
        req_imm_b = 16'h2222; req_mode_b = 2'd0;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        #1;
        tick();
        total++;
        if (req_ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready_a got=%b want=0", req_ready_a); end
        tick();
        total++;
        if (rsp_valid_a !== 1'b0 || rsp_data_a !== 32'h0 || rsp_err_a !== 1'b0) begin
            bad++; $display("FAIL reset_rsp_a got v=%b d=%h e=%b want 0/0/0", rsp_valid_a, rsp_data_a, rsp_err_a);
        end
        total++;
        if (rsp_valid_b !== 1'b0 || conflict_cnt !== 16'd0 || s_conflict_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_state got vb=%b cnt=%0d scnt=%0d want 0", rsp_valid_b, conflict_cnt, s_conflict_cnt);
        end
        rst = 1'b1;
        #1;
        total++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b0) begin
            bad++; $display("FAIL reset_first_grant got a=%b b=%b want a=1 b=0", req_ready_a, req_ready_b);
        end
        tick();
        total++;
        if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h0000_1111) begin
            bad++; $display("FAIL reset_first_rsp got v=%b d=%h want 1/00001111", rsp_valid_a, rsp_data_a);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms [5] = '{16'h8001, 16'h7FFF, 16'h8001, 16'h1234, 16'hF000};
        logic [1:0]  modes[5] = '{2'd0, 2'd1 - 2'd1, 2'd1, 2'd2, 2'd3};
        logic [31:0] exps [5] = '{32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_8001, 32'h1234_0000, 32'hFFFF_F000};
        bit          errs [5] = '{0, 0, 0, 0, 1};
        apply_reset();
        req_valid_b = 1'b0;
        req_imm_b   = 'x;
        rsp_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid_a = 1'b1;
            req_imm_a   = imms[i];
            req_mode_a  = modes[i];
            #1;
            total++;
            if (req_ready_a !== 1'b1) begin bad++; $display("FAIL mode%0d_ready got=%b want=1", i, req_ready_a); end
            tick();
            total++;
            if (rsp_valid_a !== 1'b1 || rsp_data_a !== exps[i] || rsp_err_a !== errs[i]
                || rsp_data_a !== m_data[0]) begin
                bad++; $display("FAIL mode%0d_rsp got v=%b d=%h e=%b want 1/%h/%b",
                                i, rsp_valid_a, rsp_data_a, rsp_err_a, exps[i], errs[i]);
            end
        end
        req_valid_a = 1'b0;
        tick();
        total++;
        if (rsp_valid_a !== 1'b0) begin bad++; $display("FAIL mode_drain got=%b want=0", rsp_valid_a); end
        req_imm_b = 16'h0;
    endtask

    task automatic test_contention();
        apply_reset();
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_imm_a  = 16'($urandom); req_mode_a = 2'($urandom);
            req_imm_b  = 16'($urandom); req_mode_b = 2'($urandom);
            #1;
            total++;
            if (req_ready_a !== ((i % 2) == 0) || req_ready_b !== ((i % 2) == 1)) begin
                bad++; $display("FAIL contention_grant%0d got a=%b b=%b want a=%0d", i, req_ready_a, req_ready_b, (i % 2) == 0);
            end
            tick();
            total++;
            if (((i % 2) == 0 && rsp_data_a !== ext_value(req_imm_a, req_mode_a)) ||
                ((i % 2) == 1 && rsp_data_b !== ext_value(req_imm_b, req_mode_b))) begin
                bad++; $display("FAIL contention_data%0d got a=%h b=%h", i, rsp_data_a, rsp_data_b);
            end
        end
        total++;
        if (conflict_cnt !== 16'd6) begin bad++; $display("FAIL contention_cnt got=%0d want=6", conflict_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        apply_reset();
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        req_imm_a = 16'hABCD; req_mode_a = 2'd1;
        tick();
        held = 32'h0000_ABCD;
        rsp_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_imm_a = 16'($urandom); req_imm_b = 16'($urandom);
            #1;
            total++;
            if (req_ready_a !== 1'b0 || req_ready_b !== 1'b1) begin
                bad++; $display("FAIL bp_grant%0d got a=%b b=%b want a=0 b=1", i, req_ready_a, req_ready_b);
            end
            tick();
            total++;
            if (rsp_valid_a !== 1'b1 || rsp_data_a !== held || conflict_cnt !== 16'd1) begin
                bad++; $display("FAIL bp_hold%0d got v=%b d=%h cnt=%0d want 1/%h/1", i, rsp_valid_a, rsp_data_a, conflict_cnt, held);
            end
        end
        rsp_ready_a = 1'b1;
        req_imm_a = 16'h0042; req_mode_a = 2'd2;
        #1;
        total++;
        if (req_ready_a !== 1'b1) begin bad++; $display("FAIL bp_release_grant got=%b want=1", req_ready_a); end
        tick();
        total++;
        if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'h0042_0000) begin
            bad++; $display("FAIL bp_release_rsp got v=%b d=%h want 1/00420000", rsp_valid_a, rsp_data_a);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (s_conflict_cnt !== 3'((i + 1 < 7) ? i + 1 : 7) || conflict_cnt !== 16'(i + 1)) begin
                bad++; $display("FAIL sat%0d got s=%0d w=%0d want s=%0d w=%0d", i, s_conflict_cnt, conflict_cnt,
                                (i + 1 < 7) ? i + 1 : 7, i + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req_valid_a = 1'b0; req_valid_b = 1'b1;
        req_imm_b = 16'h5A5A; req_mode_b = 2'd0;
        rsp_ready_b = 1'b0;
        tick();
        total++;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== 32'h0000_5A5A) begin
            bad++; $display("FAIL midrst_grant got v=%b d=%h want 1/00005a5a", rsp_valid_b, rsp_data_b);
        end
        rst = 1'b0;
        tick();
        total++;
        if (rsp_valid_b !== 1'b0 || rsp_data_b !== 32'h0) begin
            bad++; $display("FAIL midrst_clear got v=%b d=%h want 0/0", rsp_valid_b, rsp_data_b);
        end
        rst = 1'b1; req_valid_a = 1'b1; rsp_ready_b = 1'b1;
        #1;
        total++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b0) begin
            bad++; $display("FAIL midrst_ptr got a=%b b=%b want a=1 b=0", req_ready_a, req_ready_b);
        end
        tick();
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 400; i++) begin
            req_valid_a = ($urandom_range(0, 3) != 0);
            req_valid_b = ($urandom_range(0, 3) != 0);
            rsp_ready_a = ($urandom_range(0, 2) != 0);
            rsp_ready_b = ($urandom_range(0, 2) != 0);
            req_imm_a = 16'($urandom); req_mode_a = 2'($urandom);
            req_imm_b = 16'($urandom); req_mode_b = 2'($urandom);
            #1;
            w = model_winner();
            total++;
            if (req_ready_a !== (w == 0) || req_ready_b !== (w == 1)) begin
                bad++; $display("FAIL rand_grant%0d got a=%b b=%b want winner=%0d", i, req_ready_a, req_ready_b, w);
            end
            tick();
            total++;
            if (rsp_valid_a !== m_valid[0] || rsp_valid_b !== m_valid[1] ||
                (m_valid[0] && (rsp_data_a !== m_data[0] || rsp_err_a !== m_err[0])) ||
                (m_valid[1] && (rsp_data_b !== m_data[1] || rsp_err_b !== m_err[1])) ||
                conflict_cnt !== 16'(m_cnt16) || s_conflict_cnt !== 3'(m_cnt3)) begin
                bad++; $display("FAIL rand_rsp%0d got va=%b da=%h vb=%b db=%h cnt=%0d want va=%b da=%h vb=%b db=%h cnt=%0d",
                                i, rsp_valid_a, rsp_data_a, rsp_valid_b, rsp_data_b, conflict_cnt,
                                m_valid[0], m_data[0], m_valid[1], m_data[1], m_cnt16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_contention();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares one 16->32 immediate extension unit between two requesters: port A (ALU/load-store address path) and port B (branch-target path).
- Each port has a valid/ready request channel and a registered valid/ready response channel.
- Arbitration is round-robin.
- Supports sign-extend, zero-extend and upper-immediate modes.

Parameters:
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-low reset.
- ReqValidA  input  1  port A request valid.
- ReqReadyA  output  1  port A request accepted this cycle when high with ReqValidA.
- ReqImmA  input  16  port A immediate.
- ReqModeA  input  2  port A mode: 00 sign, 01 zero, 10 upper, 11 reserved.
- RspValidA  output  1  port A result valid.
- RspReadyA  input  1  port A consumer ready.
- RspDataA  output  32  port A extended result.
- RspErrA  output  1  port A result came from a reserved mode.
- ReqValidB, ReqReadyB, ReqImmB, ReqModeB, RspValidB, RspReadyB, RspDataB, RspErrB: identical to the A ports, for port B.
- ConflictCnt  output  CNT_W  saturating count of cycles where both ports were eligible.

Behaviour:
- Reset (Rst=0 at a clock edge):
  - RspValidA/B=0, RspDataA/B=0, RspErrA/B=0, ConflictCnt=0.
  - Priority pointer = A.
  - Reset overrides any in-flight request or held response; the held response is discarded.
- Slot free: slot_free_x = !RspValidx || RspReadyx. A same-cycle drain frees the slot.
- Eligibility: elig_x = ReqValidx && slot_free_x.
- Grant:
  - Only one port eligible -> that port wins.
  - Both eligible -> the port named by the pointer wins.
  - Neither eligible -> no grant.
- Handshake:
  - ReqReadyx = grant_x. It is combinational from this cycle's valids and response state.
  - Only one ReqReady is high per cycle.
  - ReqReadyx never depends on ReqImm or ReqMode.
- Pointer update: after any grant, the pointer moves to the non-granted port. With no grant, the pointer holds.
- Extension is combinational on the granted immediate imm; the result is registered:
  - mode 00: {{16{imm[15]}}, imm}.
  - mode 01: {16'h0000, imm}.
  - mode 10: {imm, 16'h0000}.
  - mode 11: handled as mode 00, and RspErrx=1 with the result. RspErrx=0 for all other modes.
- Latency: request accepted at edge N -> RspValidx=1 with RspDatax/RspErrx valid after edge N (one cycle).
- Response hold: RspValidx/RspDatax/RspErrx stay stable until a cycle with RspReadyx=1.
  - On that edge, a new grant to the same port reloads the response register (back-to-back, one result per cycle).
  - Otherwise RspValidx clears at that edge.
- The non-granted port's response register is unaffected by the other port's grant.
- Throughput: aggregate 1 result/cycle. With both ports continuously eligible, grants alternate A,B,A,B...
- ConflictCnt: increments on each edge where elig_A && elig_B; saturates at all-ones and does not wrap.
- ReqValid may drop without a handshake; no state is kept for non-granted requests.
- Unknown/X on ReqImm of a non-granted port must not propagate.

Test Plan:
- Reset: hold Rst=0 two cycles with ReqValidA=1 -> ReqReadyA=0 during reset, RspValidA=0, RspDataA=0, ConflictCnt=0. First grant after Rst=1 goes to A when both are valid.
- Modes on port A, RspReadyA=1, one request per cycle:
  - imm 16'h8001 mode 00 -> 32'hFFFF8001, RspErrA=0.
  - imm 16'h7FFF mode 00 -> 32'h00007FFF.
  - imm 16'h8001 mode 01 -> 32'h00008001.
  - imm 16'h1234 mode 10 -> 32'h12340000.
  - imm 16'hF000 mode 11 -> 32'hFFFFF000, RspErrA=1.
  - Each response appears exactly one cycle after its handshake.
- Contention: both ports valid every cycle, RspReady=1 on both, 6 cycles -> grants A,B,A,B,A,B; ConflictCnt=6.
- Backpressure: port A response held with RspReadyA=0 for 3 cycles and ReqValidA=1 -> ReqReadyA=0 throughout; RspDataA is stable; port B is granted every cycle meanwhile; ConflictCnt does not increment. Then RspReadyA=1 -> A is granted the same cycle (slot frees on drain) and the new result appears next cycle.
- Saturation: CNT_W=3, both ports eligible 10 cycles -> ConflictCnt reaches 7 and holds 7.
- Mid-operation reset: grant to B at edge N, Rst=0 at edge N+1 -> RspValidB=0 after N+1, pointer returns to A, held result is lost.
